// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_CORE         = 1'b0;
    localparam logic PORT_DBG          = 1'b1;
    localparam int   DEFAULT_MEM_BYTES = 100;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way grant selection, round-robin or fixed port-0 priority.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic fixed,
    output logic grant
);

    always_comb begin
        grant = PORT_CORE;
        if (valid0 && valid1) begin
            grant = fixed ? PORT_CORE : ~last_grant;
        end else if (valid1) begin
            grant = PORT_DBG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one byte-addressed data memory between the core and the
//            debug/loader port with range-checked, registered responses.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int HEIGHT     = 16,
    parameter int MEM_BYTES  = DEFAULT_MEM_BYTES,
    parameter int FIXED_PRIO = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [HEIGHT-1:0] req0_addr,
    input  logic [WIDTH-1:0]  req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [WIDTH-1:0]  rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [HEIGHT-1:0] req1_addr,
    input  logic [WIDTH-1:0]  req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [WIDTH-1:0]  rsp1_rdata,
    output logic              rsp1_err,
    output logic              mem_we,
    output logic              mem_re,
    output logic [HEIGHT-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    // Highest legal word address: the upper byte must still lie in memory.
    localparam logic [HEIGHT:0] c_last_addr = (HEIGHT + 1)'(MEM_BYTES - 2);

    state_t              r_state;
    logic                r_last_grant;
    logic                r_port;
    logic                r_err;
    logic                r_mem_we;
    logic                r_mem_re;
    logic [HEIGHT-1:0]   r_mem_addr;
    logic [WIDTH-1:0]    r_mem_wdata;
    logic                r_rsp0_valid;
    logic [WIDTH-1:0]    r_rsp0_rdata;
    logic                r_rsp0_err;
    logic                r_rsp1_valid;
    logic [WIDTH-1:0]    r_rsp1_rdata;
    logic                r_rsp1_err;

    logic                w_grant;
    logic                w_accept;
    logic                w_req_we;
    logic [HEIGHT-1:0]   w_req_addr;
    logic [WIDTH-1:0]    w_req_wdata;
    logic                w_req_ok;
    logic [WIDTH-1:0]    w_rsp_data;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (r_last_grant),
        .fixed      (FIXED_PRIO != 0),
        .grant      (w_grant)
    );

    assign w_accept    = (r_state == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready  = w_accept && (w_grant == PORT_CORE);
    assign req1_ready  = w_accept && (w_grant == PORT_DBG);

    assign w_req_we    = (w_grant == PORT_DBG) ? req1_we    : req0_we;
    assign w_req_addr  = (w_grant == PORT_DBG) ? req1_addr  : req0_addr;
    assign w_req_wdata = (w_grant == PORT_DBG) ? req1_wdata : req0_wdata;
    assign w_req_ok    = ({1'b0, w_req_addr} <= c_last_addr);

    // Only an in-range read returns memory data; writes and errors return 0.
    assign w_rsp_data  = r_mem_re ? mem_rdata : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_last_grant <= PORT_DBG;
            r_port       <= PORT_CORE;
            r_err        <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp0_err   <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_rdata <= '0;
            r_rsp1_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_port       <= w_grant;
                        r_last_grant <= w_grant;
                        r_err        <= !w_req_ok;
                        r_mem_we     <= w_req_we && w_req_ok;
                        r_mem_re     <= !w_req_we && w_req_ok;
                        r_mem_addr   <= w_req_ok ? w_req_addr  : '0;
                        r_mem_wdata  <= w_req_ok ? w_req_wdata : '0;
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_mem_we    <= 1'b0;
                    r_mem_re    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    if (r_port == PORT_CORE) begin
                        r_rsp0_valid <= 1'b1;
                        r_rsp0_rdata <= w_rsp_data;
                        r_rsp0_err   <= r_err;
                    end else begin
                        r_rsp1_valid <= 1'b1;
                        r_rsp1_rdata <= w_rsp_data;
                        r_rsp1_err   <= r_err;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_re     = r_mem_re;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp0_err   = r_rsp0_err;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_rdata = r_rsp1_rdata;
    assign rsp1_err   = r_rsp1_err;

endmodule
`default_nettype wire
